// File: rtl/vram_term_ctrl_if.sv
// ---------------------------------------------------------------------------
// naive_bus : simple request/grant memory bus used by the video terminal.
//
// Signals
//   rd_req  / rd_addr                    read request (master -> slave)
//   wr_req  / wr_addr / wr_be / wr_data  write request (master -> slave)
//   wr_gnt                               write grant (slave -> master); a
//                                        cycle with wr_req=1 and wr_gnt=1
//                                        completes one write
//
// Modports
//   master : drives requests, samples the grant
//   slave  : samples requests, drives the grant
// ---------------------------------------------------------------------------
interface naive_bus;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic        wr_req;
   logic [31:0] wr_addr;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic        wr_gnt;

   modport master (
      output rd_req,
      output rd_addr,
      output wr_req,
      output wr_addr,
      output wr_be,
      output wr_data,
      input  wr_gnt
   );

   modport slave (
      input  rd_req,
      input  rd_addr,
      input  wr_req,
      input  wr_addr,
      input  wr_be,
      input  wr_data,
      output wr_gnt
   );
endinterface

// File: rtl/vram_term_ctrl.sv
// ---------------------------------------------------------------------------
// vram_term_ctrl : character terminal controller writing into video RAM.
//
// Accepts one ASCII character (or control code) at a time and turns it into
// byte writes on a naive_bus master port. Printable characters are written at
// the cursor, CR/LF/BS/FF move the cursor or clear the screen.
//
// Parameters
//   BASE_ADDR  byte address of cell (0,0)
//   COLS       characters per row
//   ROWS       rows per screen
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   i_char     character / control code
//   i_valid    i_char valid (taken when o_ready=1)
//   o_ready    high only in IDLE
//   o_busy     high while a bus sequence runs
//   o_cur_col  cursor column
//   o_cur_row  cursor row
//   bus        naive_bus master (writes only; reads tied off)
//
// Build option
//   VRAM_TERM_AUTOCLR_EN  when defined, every row advance clears the new row
//                         (CLR_LINE state); when undefined, CLR_LINE is absent.
// ---------------------------------------------------------------------------
module vram_term_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h0002_0000,
   parameter int          COLS      = 86,
   parameter int          ROWS      = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  i_char,
   input  logic        i_valid,
   output logic        o_ready,
   output logic        o_busy,
   output logic [6:0]  o_cur_col,
   output logic [4:0]  o_cur_row,
   naive_bus.master    bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PUT      = 2'd1,
`ifdef VRAM_TERM_AUTOCLR_EN
      CLR_LINE = 2'd2,
`endif
      CLR_ALL  = 2'd3
   } state_t;

   localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
   localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
   localparam logic [15:0] LAST_CELL = 16'(ROWS * COLS - 1);
`ifdef VRAM_TERM_AUTOCLR_EN
   localparam logic [15:0] LAST_LINE_IDX = 16'(COLS - 1);
`endif
   localparam logic [31:0] SPACE4    = 32'h2020_2020;

   state_t      r_state,   w_state;
   logic [6:0]  r_curCol,  w_curCol;
   logic [4:0]  r_curRow,  w_curRow;
   logic [6:0]  r_pendCol, w_pendCol;
   logic [4:0]  r_pendRow, w_pendRow;
   logic        r_wrReq,   w_wrReq;
   logic [31:0] r_wrAddr,  w_wrAddr;
   logic [3:0]  r_wrBe,    w_wrBe;
   logic [31:0] r_wrData,  w_wrData;
   logic [15:0] r_idx,     w_idx;
`ifdef VRAM_TERM_AUTOCLR_EN
   logic        r_pendClr, w_pendClr;
`endif

   // Byte address of a screen cell.
   function automatic logic [31:0] cellAddr(input logic [4:0] row, input logic [6:0] col);
      return BASE_ADDR + (32'(row) * 32'(COLS)) + 32'(col);
   endfunction

   // One-hot byte lane for a byte address.
   function automatic logic [3:0] laneBe(input logic [31:0] addr);
      return 4'b0001 << addr[1:0];
   endfunction

   // Row advance wraps from the last row back to the top.
   function automatic logic [4:0] rowAdvance(input logic [4:0] row);
      return (row == LAST_ROW) ? 5'd0 : row + 5'd1;
   endfunction

   // State and datapath registers. Reset abandons any write in flight: the
   // request drops immediately and nothing is remembered for a retry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_curCol  <= '0;
         r_curRow  <= '0;
         r_pendCol <= '0;
         r_pendRow <= '0;
         r_wrReq   <= 1'b0;
         r_wrAddr  <= '0;
         r_wrBe    <= '0;
         r_wrData  <= '0;
         r_idx     <= '0;
`ifdef VRAM_TERM_AUTOCLR_EN
         r_pendClr <= 1'b0;
`endif
      end else begin
         r_state   <= w_state;
         r_curCol  <= w_curCol;
         r_curRow  <= w_curRow;
         r_pendCol <= w_pendCol;
         r_pendRow <= w_pendRow;
         r_wrReq   <= w_wrReq;
         r_wrAddr  <= w_wrAddr;
         r_wrBe    <= w_wrBe;
         r_wrData  <= w_wrData;
         r_idx     <= w_idx;
`ifdef VRAM_TERM_AUTOCLR_EN
         r_pendClr <= w_pendClr;
`endif
      end
   end

   // Next-state logic. Bus fields are loaded only when a new write starts
   // and otherwise hold, so they stay stable until the grant arrives. A
   // single PUT write keeps its post-write cursor in r_pend*, applied on the
   // grant. Clears walk r_idx one cell per grant; cells are contiguous so
   // the address simply increments.
   always_comb begin
      w_state   = r_state;
      w_curCol  = r_curCol;
      w_curRow  = r_curRow;
      w_pendCol = r_pendCol;
      w_pendRow = r_pendRow;
      w_wrReq   = r_wrReq;
      w_wrAddr  = r_wrAddr;
      w_wrBe    = r_wrBe;
      w_wrData  = r_wrData;
      w_idx     = r_idx;
`ifdef VRAM_TERM_AUTOCLR_EN
      w_pendClr = r_pendClr;
`endif

      case (r_state)
         IDLE: begin
            if (i_valid) begin
               case (i_char)
                  8'h0D: begin
                     w_curCol = '0;
                  end
                  8'h0A: begin
                     w_curCol = '0;
                     w_curRow = rowAdvance(r_curRow);
`ifdef VRAM_TERM_AUTOCLR_EN
                     w_state  = CLR_LINE;
                     w_idx    = '0;
                     w_wrReq  = 1'b1;
                     w_wrAddr = cellAddr(rowAdvance(r_curRow), 7'd0);
                     w_wrBe   = laneBe(w_wrAddr);
                     w_wrData = SPACE4;
`endif
                  end
                  8'h08: begin
                     if (r_curCol != 7'd0) begin
                        w_state   = PUT;
                        w_pendCol = r_curCol - 7'd1;
                        w_pendRow = r_curRow;
                        w_wrReq   = 1'b1;
                        w_wrAddr  = cellAddr(r_curRow, r_curCol - 7'd1);
                        w_wrBe    = laneBe(w_wrAddr);
                        w_wrData  = SPACE4;
`ifdef VRAM_TERM_AUTOCLR_EN
                        w_pendClr = 1'b0;
`endif
                     end
                  end
                  8'h0C: begin
                     w_state  = CLR_ALL;
                     w_idx    = '0;
                     w_wrReq  = 1'b1;
                     w_wrAddr = BASE_ADDR;
                     w_wrBe   = laneBe(w_wrAddr);
                     w_wrData = SPACE4;
                  end
                  default: begin
                     w_state  = PUT;
                     w_wrReq  = 1'b1;
                     w_wrAddr = cellAddr(r_curRow, r_curCol);
                     w_wrBe   = laneBe(w_wrAddr);
                     w_wrData = {4{i_char}};
                     if (r_curCol == LAST_COL) begin
                        w_pendCol = '0;
                        w_pendRow = rowAdvance(r_curRow);
`ifdef VRAM_TERM_AUTOCLR_EN
                        w_pendClr = 1'b1;
`endif
                     end else begin
                        w_pendCol = r_curCol + 7'd1;
                        w_pendRow = r_curRow;
`ifdef VRAM_TERM_AUTOCLR_EN
                        w_pendClr = 1'b0;
`endif
                     end
                  end
               endcase
            end
         end

         PUT: begin
            if (bus.wr_gnt) begin
               w_curCol = r_pendCol;
               w_curRow = r_pendRow;
               w_wrReq  = 1'b0;
               w_state  = IDLE;
`ifdef VRAM_TERM_AUTOCLR_EN
               if (r_pendClr) begin
                  w_state  = CLR_LINE;
                  w_idx    = '0;
                  w_wrReq  = 1'b1;
                  w_wrAddr = cellAddr(r_pendRow, 7'd0);
                  w_wrBe   = laneBe(w_wrAddr);
                  w_wrData = SPACE4;
               end
`endif
            end
         end

`ifdef VRAM_TERM_AUTOCLR_EN
         CLR_LINE: begin
            if (bus.wr_gnt) begin
               if (r_idx == LAST_LINE_IDX) begin
                  w_wrReq = 1'b0;
                  w_state = IDLE;
               end else begin
                  w_idx    = r_idx + 16'd1;
                  w_wrAddr = r_wrAddr + 32'd1;
                  w_wrBe   = laneBe(w_wrAddr);
               end
            end
         end
`endif

         CLR_ALL: begin
            if (bus.wr_gnt) begin
               if (r_idx == LAST_CELL) begin
                  w_wrReq  = 1'b0;
                  w_state  = IDLE;
                  w_curCol = '0;
                  w_curRow = '0;
               end else begin
                  w_idx    = r_idx + 16'd1;
                  w_wrAddr = r_wrAddr + 32'd1;
                  w_wrBe   = laneBe(w_wrAddr);
               end
            end
         end

         default: begin
            w_state = IDLE;
            w_wrReq = 1'b0;
         end
      endcase
   end

   assign o_ready     = (r_state == IDLE);
   assign o_busy      = (r_state != IDLE);
   assign o_cur_col   = r_curCol;
   assign o_cur_row   = r_curRow;

   assign bus.rd_req  = 1'b0;
   assign bus.rd_addr = '0;
   assign bus.wr_req  = r_wrReq;
   assign bus.wr_addr = r_wrAddr;
   assign bus.wr_be   = r_wrBe;
   assign bus.wr_data = r_wrData;

endmodule

// File: tb/tb_vram_term_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vram_term_ctrl : directed bench for vram_term_ctrl with a write
// scoreboard. A small terminal model pushes the writes each character should
// cause; a bus monitor pops and compares them as the writes are granted.
// ---------------------------------------------------------------------------
module tb_vram_term_ctrl;

   localparam logic [31:0] BASE = 32'h0002_0000;
   localparam int          COLS = 86;
   localparam int          ROWS = 32;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] i_char;
   logic       i_valid;
   logic       o_ready;
   logic       o_busy;
   logic [6:0] o_cur_col;
   logic [4:0] o_cur_row;

   naive_bus bus ();

   wr_t sb[$];
   wr_t monExp;
   int  checks  = 0;
   int  errors  = 0;
   int  wrCount = 0;
   int  tbCol   = 0;
   int  tbRow   = 0;
   int  mark;

   vram_term_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_char    (i_char),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .o_busy    (o_busy),
      .o_cur_col (o_cur_col),
      .o_cur_row (o_cur_row),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic logic [3:0] beOf(input logic [31:0] a);
      case (a[1:0])
         2'd0:    return 4'b0001;
         2'd1:    return 4'b0010;
         2'd2:    return 4'b0100;
         default: return 4'b1000;
      endcase
   endfunction

   task automatic pushWrite(input int row, input int col, input logic [7:0] ch);
      wr_t w;
      w.addr = BASE + 32'(row * COLS + col);
      w.be   = beOf(w.addr);
      w.data = {4{ch}};
      sb.push_back(w);
   endtask

   task automatic advanceRow();
      tbRow = (tbRow + 1) % ROWS;
`ifdef VRAM_TERM_AUTOCLR_EN
      for (int c = 0; c < COLS; c++) pushWrite(tbRow, c, 8'h20);
`endif
   endtask

   // Terminal model: updates the bench cursor and queues expected writes.
   task automatic modelChar(input logic [7:0] ch);
      case (ch)
         8'h0D: tbCol = 0;
         8'h0A: begin tbCol = 0; advanceRow(); end
         8'h08: begin
            if (tbCol > 0) begin
               tbCol--;
               pushWrite(tbRow, tbCol, 8'h20);
            end
         end
         8'h0C: begin
            for (int k = 0; k < ROWS * COLS; k++) pushWrite(k / COLS, k % COLS, 8'h20);
            tbCol = 0;
            tbRow = 0;
         end
         default: begin
            pushWrite(tbRow, tbCol, ch);
            tbCol++;
            if (tbCol == COLS) begin tbCol = 0; advanceRow(); end
         end
      endcase
   endtask

   task automatic checkCursor(input string tag);
      checkOutput({tag, "_col"}, 32'(o_cur_col), 32'(tbCol));
      checkOutput({tag, "_row"}, 32'(o_cur_row), 32'(tbRow));
   endtask

   // Present one character and return #1 after the accepting edge.
   task automatic driveChar(input logic [7:0] ch);
      int n = 0;
      modelChar(ch);
      while (o_ready !== 1'b1 && n < 8000) begin @(posedge clk); #1; n++; end
      checkOutput("ready_wait", 32'(o_ready), 32'd1);
      i_char  = ch;
      i_valid = 1'b1;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_char  = 8'h00;
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while (o_ready !== 1'b1 && n < 8000) begin @(posedge clk); #1; n++; end
      checkOutput({tag, "_idle"}, 32'(o_ready), 32'd1);
      checkOutput({tag, "_drained"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic applyStimulus(input logic [7:0] ch, input string tag);
      driveChar(ch);
      waitIdle(tag);
   endtask

   // Bus monitor: a write completes in a cycle with wr_req and wr_gnt high.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.wr_req === 1'b1 && bus.wr_gnt === 1'b1) begin
         wrCount++;
         checkOutput("expected_write", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            monExp = sb.pop_front();
            checkOutput("wr_addr", bus.wr_addr, monExp.addr);
            checkOutput("wr_be", 32'(bus.wr_be), 32'(monExp.be));
            checkOutput("wr_data", bus.wr_data, monExp.data);
            checkOutput("busy_at_gnt", 32'(o_busy), 32'd1);
         end
      end
   end

   initial begin
      rst_n      = 1'b0;
      i_valid    = 1'b0;
      i_char     = 8'h00;
      bus.wr_gnt = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Reset values
      checkOutput("rst_wr_req", 32'(bus.wr_req), 32'd0);
      checkOutput("rst_wr_addr", bus.wr_addr, 32'd0);
      checkOutput("rst_wr_be", 32'(bus.wr_be), 32'd0);
      checkOutput("rst_wr_data", bus.wr_data, 32'd0);
      checkOutput("rst_busy", 32'(o_busy), 32'd0);
      checkOutput("rst_rd_req", 32'(bus.rd_req), 32'd0);
      checkOutput("rst_rd_addr", bus.rd_addr, 32'd0);
      checkCursor("rst");
      rst_n = 1'b1;
      checkOutput("ready_after_rst", 32'(o_ready), 32'd1);

      // 'A' with grant tied high
      applyStimulus(8'h41, "char_A");
      checkOutput("wrcount_A", 32'(wrCount), 32'd1);
      checkCursor("after_A");

      // 0x42 at column 3 with the grant held off for 5 cycles
      applyStimulus(8'h62, "char_b");
      applyStimulus(8'h63, "char_c");
      checkCursor("col3");
      mark = wrCount;
      bus.wr_gnt = 1'b0;
      driveChar(8'h42);
      for (int i = 0; i < 5; i++) begin
         checkOutput("stall_req", 32'(bus.wr_req), 32'd1);
         checkOutput("stall_addr", bus.wr_addr, BASE + 32'd3);
         checkOutput("stall_be", 32'(bus.wr_be), 32'h8);
         checkOutput("stall_ready", 32'(o_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      checkOutput("stall_no_write", 32'(wrCount), 32'(mark));
      bus.wr_gnt = 1'b1;
      waitIdle("stall");
      checkOutput("stall_one_write", 32'(wrCount), 32'(mark + 1));
      checkCursor("after_stall");

      // Walk to (85,31) and write the last cell
      applyStimulus(8'h0D, "cr_home");
      for (int i = 0; i < ROWS - 1; i++) applyStimulus(8'h0A, "lf");
      for (int i = 0; i < COLS - 1; i++) applyStimulus(8'(8'h61 + (i % 26)), "fill");
      checkOutput("at_last_col", 32'(o_cur_col), 32'd85);
      checkOutput("at_last_row", 32'(o_cur_row), 32'd31);
      applyStimulus(8'h43, "last_cell");
      checkCursor("wrap");

      // Form feed: clear all cells, busy drops the cycle after the last grant
      applyStimulus(8'h71, "pre_ff_q");
      applyStimulus(8'h72, "pre_ff_r");
      mark = wrCount;
      driveChar(8'h0C);
      checkOutput("ff_busy", 32'(o_busy), 32'd1);
      for (int n = 0; n < 6000 && sb.size() != 0; n++) begin @(posedge clk); #1; end
      checkOutput("ff_drained", 32'(sb.size()), 32'd0);
      checkOutput("ff_busy_low", 32'(o_busy), 32'd0);
      checkOutput("ff_ready", 32'(o_ready), 32'd1);
      checkOutput("ff_count", 32'(wrCount - mark), 32'(ROWS * COLS));
      checkCursor("ff");

      // Backspace at column 0 does nothing
      mark = wrCount;
      applyStimulus(8'h08, "bs_col0");
      checkOutput("bs_col0_nowrite", 32'(wrCount), 32'(mark));
      checkCursor("bs_col0");

      // Backspace at column 1 blanks column 0
      applyStimulus(8'h5A, "char_Z");
      applyStimulus(8'h08, "bs_col1");
      checkCursor("bs_col1");

      // Carriage return from column 10
      for (int i = 0; i < 10; i++) applyStimulus(8'(8'h30 + i), "digits");
      checkCursor("col10");
      mark = wrCount;
      driveChar(8'h0D);
      checkOutput("cr_col", 32'(o_cur_col), 32'd0);
      checkOutput("cr_ready", 32'(o_ready), 32'd1);
      checkOutput("cr_busy", 32'(o_busy), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("cr_nowrite", 32'(wrCount), 32'(mark));

      // Reset in the middle of a full clear
      driveChar(8'h0C);
      repeat (20) @(posedge clk);
      #1;
      checkOutput("midclr_busy", 32'(o_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_wr_req", 32'(bus.wr_req), 32'd0);
      checkOutput("midrst_busy", 32'(o_busy), 32'd0);
      checkOutput("midrst_ready", 32'(o_ready), 32'd1);
      sb.delete();
      tbCol = 0;
      tbRow = 0;
      checkCursor("midrst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mark = wrCount;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("postrst_nowrite", 32'(wrCount), 32'(mark));
      checkOutput("postrst_wr_req", 32'(bus.wr_req), 32'd0);
      applyStimulus(8'h41, "postrst_A");
      checkCursor("postrst_A");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vram_term_ctrl.md
VRAM_TERM_CTRL -- requirements
Module: vram_term_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0002_0000, byte address of video RAM cell (0,0).
REQ-002 SHALL have parameter COLS, default 86, characters per row.
REQ-003 SHALL have parameter ROWS, default 32, rows per screen.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_char  input  8  ASCII character or control code.
REQ-007 SHALL have port i_valid  input  1  i_char valid.
REQ-008 SHALL have port o_ready  output  1  block can accept a character.
REQ-009 SHALL have port o_busy  output  1  a bus sequence is in progress.
REQ-010 SHALL have port o_cur_col  output  7  cursor column, 0..COLS-1.
REQ-011 SHALL have port o_cur_row  output  5  cursor row, 0..ROWS-1.
REQ-012 SHALL have port bus  naive_bus.master  --  write master into video RAM.

Function
REQ-013 SHALL hold bus.rd_req=0 and bus.rd_addr=0 permanently.
REQ-014 SHALL use states IDLE, PUT, CLR_LINE, CLR_ALL; o_ready=1 only in IDLE; o_busy = (state != IDLE).
REQ-015 SHALL accept a character in any cycle where i_valid and o_ready are both 1; i_char is registered in that cycle.
REQ-016 SHALL compute the cell byte address as BASE_ADDR + row*COLS + col in 32 bits.
REQ-017 SHALL drive bus.wr_be one-hot from address[1:0] (00->0001, 11->1000) and bus.wr_data as the byte replicated into all four lanes.
REQ-018 SHALL assert bus.wr_req in the cycle after acceptance; wr_req, wr_addr, wr_be and wr_data stay stable until a cycle with bus.wr_gnt=1, which completes that write.
REQ-019 Printable code (anything not listed in REQ-020..023): IDLE->PUT, write i_char at the cursor, then col+1.
REQ-019a If col was COLS-1, col becomes 0 and the row advances per REQ-024.
REQ-020 0x0D (CR) SHALL set col=0 with no bus write and stay in IDLE; o_ready stays 1.
REQ-021 0x0A (LF) SHALL set col=0 and advance the row per REQ-024.
REQ-022 0x08 (BS): if col>0, col-1 and write 0x20 at the new position (PUT); if col=0, no effect and no write.
REQ-023 0x0C (FF) SHALL enter CLR_ALL, writing 0x20 to every cell, index 0 to ROWS*COLS-1 ascending (one write per grant), then set cursor (0,0) and return to IDLE.
REQ-024 Row advance SHALL be row+1, wrapping ROWS-1 -> 0, and SHALL then follow REQ-031/REQ-032.
REQ-025 SHALL update the cursor outputs in the cycle the final write of a sequence is granted; for CR, LF and BS-at-col-0, in the cycle after acceptance.
REQ-026 SHALL return to IDLE in the cycle after the final grant of a sequence.
REQ-027 i_char and i_valid SHALL be ignored while o_ready=0; no input buffering.

Reset
REQ-028 On rst_n=0, state SHALL become IDLE immediately, including mid-sequence; any pending write is abandoned and not retried.
REQ-029 Reset values: bus.wr_req=0, wr_addr=0, wr_be=0, wr_data=0, o_cur_col=0, o_cur_row=0, o_busy=0.
REQ-030 o_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-031 With macro VRAM_TERM_AUTOCLR_EN defined, every row advance SHALL enter CLR_LINE and write 0x20 to columns 0..COLS-1 of the new row, ascending, before returning to IDLE.
REQ-032 Without VRAM_TERM_AUTOCLR_EN, a row advance SHALL issue no extra writes; CLR_LINE is not built.

Verification
REQ-033 From reset, send 'A' (0x41) with wr_gnt tied high -> one write: addr BASE_ADDR+0, be 0001, data 0x41414141; cursor then (1,0).
REQ-034 Send 0x42 at cursor (3,0) with wr_gnt low for 5 cycles -> wr_req held with stable addr BASE_ADDR+3, be 1000; exactly one write completes; o_ready low throughout.
REQ-035 At cursor (85,31), send 0x43 -> write at BASE_ADDR+2751; cursor then (0,0).
REQ-035a With AUTOCLR: 86 writes of 0x20 follow to addresses BASE_ADDR+0..85; without AUTOCLR: none.
REQ-036 Send 0x0C -> 2752 writes of 0x20 to addresses BASE_ADDR+0..2751; cursor (0,0); o_busy high until the cycle after the last grant.
REQ-037 Send BS at col 0 -> no write; then CR at col 10 -> col 0 with no write; then assert rst_n=0 mid-CLR_ALL -> wr_req=0 at once and state IDLE.
